// File: rtl/ray_types_pkg.sv
// Shared fixed-point vector layout and FSM state type for the ray generator.
// Vectors are three packed Q8.24 components: x in the low word, then y, then z.
package ray_types_pkg;

  localparam int COMP_W    = 32;
  localparam int FRAC_BITS = 24;
  localparam int VEC_W     = 96;

  localparam int X_LO = 0;
  localparam int Y_LO = 32;
  localparam int Z_LO = 64;

  localparam logic [COMP_W-1:0] ONE = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } caster_state_t;

endpackage

// File: rtl/pixel_scan_gen.sv
// Pixel scan counter: walks the image in raster or tiled order.
// Raster order is treated as tiles that are one full row wide and one line tall.
module pixel_scan_gen
  import ray_types_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TILE_W  = 8,
  parameter int TILE_H  = 8,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic               tile_mode,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] W_M1    = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] H_M1    = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] TW_M1   = COORD_W'(TILE_W - 1);
  localparam logic [COORD_W-1:0] TH_M1   = COORD_W'(TILE_H - 1);
  localparam logic [COORD_W-1:0] TW_STEP = COORD_W'(TILE_W);
  localparam logic [COORD_W-1:0] TH_STEP = COORD_W'(TILE_H);
  localparam logic [COORD_W-1:0] TX_LAST = COORD_W'(IMG_W - TILE_W);
  localparam logic [COORD_W-1:0] TY_LAST = COORD_W'(IMG_H - TILE_H);

  logic [COORD_W-1:0] px, py, tx, ty;
  logic [COORD_W-1:0] px_max, py_max, tx_max, ty_max, tx_step, ty_step;

  // px/py count inside the current tile, tx/ty hold the tile origin
  assign px_max  = tile_mode ? TW_M1   : W_M1;
  assign py_max  = tile_mode ? TH_M1   : '0;
  assign tx_max  = tile_mode ? TX_LAST : '0;
  assign ty_max  = tile_mode ? TY_LAST : H_M1;
  assign tx_step = tile_mode ? TW_STEP : '0;
  assign ty_step = tile_mode ? TH_STEP : COORD_W'(1);

  assign x    = tx + px;
  assign y    = ty + py;
  assign last = (px == px_max) && (py == py_max) && (tx == tx_max) && (ty == ty_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px <= '0;
      py <= '0;
      tx <= '0;
      ty <= '0;
    end else if (clear) begin
      px <= '0;
      py <= '0;
      tx <= '0;
      ty <= '0;
    end else if (advance) begin
      if (px != px_max) begin
        px <= px + 1'b1;
      end else begin
        px <= '0;
        if (py != py_max) begin
          py <= py + 1'b1;
        end else begin
          py <= '0;
          if (tx != tx_max) begin
            tx <= tx + tx_step;
          end else begin
            tx <= '0;
            if (ty != ty_max) ty <= ty + ty_step;
            else              ty <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tiled_ray_caster.sv
// Primary ray generator: one ray per pixel from a latched camera, two-stage
// multiply/accumulate datapath, frozen entirely while ce is low.
module tiled_ray_caster
  import ray_types_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TILE_W  = 8,
  parameter int TILE_H  = 8,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               render_start,
  input  logic               tile_mode,
  input  logic [VEC_W-1:0]   camera_origin,
  input  logic [VEC_W-1:0]   camera_front,
  input  logic [VEC_W-1:0]   camera_left,
  input  logic [VEC_W-1:0]   camera_up,
  output logic [COORD_W-1:0] core_image_x,
  output logic [COORD_W-1:0] core_image_y,
  output logic [VEC_W-1:0]   core_ray_origin,
  output logic [VEC_W-1:0]   core_ray_direction,
  output logic               output_valid,
  output logic               busy,
  output logic               frame_done
);

  if (IMG_W % TILE_W != 0) begin : g_bad_tile_w
    $error("IMG_W must be a multiple of TILE_W");
  end
  if (IMG_H % TILE_H != 0) begin : g_bad_tile_h
    $error("IMG_H must be a multiple of TILE_H");
  end
  if ((IMG_W % 2 != 0) || (IMG_H % 2 != 0)) begin : g_bad_even
    $error("IMG_W and IMG_H must be even");
  end
  if (((1 << (COORD_W - 1)) <= IMG_W) || ((1 << (COORD_W - 1)) <= IMG_H)
      || (COORD_W + 1 > COMP_W)) begin : g_bad_coord_w
    $error("COORD_W does not fit the image size");
  end
  if (ONE != COMP_W'(1 << FRAC_BITS)) begin : g_bad_fixed
    $error("ONE does not match FRAC_BITS");
  end

  localparam logic [COORD_W:0] HALF_W = (COORD_W + 1)'(IMG_W / 2);
  localparam logic [COORD_W:0] HALF_H = (COORD_W + 1)'(IMG_H / 2);

  // Low word of an integer times Q8.24 is already Q8.24, and the low bits of a
  // product do not depend on operand signedness once the integer is sign-extended.
  function automatic logic [COMP_W-1:0] mul_q(input logic [COORD_W:0] d,
                                              input logic [COMP_W-1:0] v);
    logic [COMP_W-1:0] d_ext;
    d_ext = {{(COMP_W - COORD_W - 1){d[COORD_W]}}, d};
    return d_ext * v;
  endfunction

  caster_state_t      state;
  logic [VEC_W-1:0]   cam_origin, cam_front, cam_left, cam_up;
  logic               tile_q;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               scan_last;
  logic               start_ok, issue;
  logic [COORD_W:0]   dx, dy;

  logic               s1_valid, s1_last;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [COMP_W-1:0]  s1_lx, s1_ly, s1_lz, s1_ux, s1_uy, s1_uz;
  logic               out_last;

  assign start_ok   = (state == IDLE) && render_start;
  assign issue      = (state == RUN) && ce;
  assign dx         = {1'b0, scan_x} - HALF_W;
  assign dy         = {1'b0, scan_y} - HALF_H;
  assign frame_done = output_valid && ce && out_last;

  assign core_ray_origin = cam_origin;

  pixel_scan_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .COORD_W(COORD_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .advance  (issue),
    .tile_mode(tile_q),
    .x        (scan_x),
    .y        (scan_y),
    .last     (scan_last)
  );

  // Start is taken even while the core stalls; the camera stays frozen until IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      tile_q     <= 1'b0;
      cam_origin <= '0;
      cam_front  <= '0;
      cam_left   <= '0;
      cam_up     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (render_start) begin
            cam_origin <= camera_origin;
            cam_front  <= camera_front;
            cam_left   <= camera_left;
            cam_up     <= camera_up;
            tile_q     <= tile_mode;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (ce && scan_last) state <= DRAIN;
        end
        DRAIN: begin
          if (frame_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid           <= 1'b0;
      s1_last            <= 1'b0;
      s1_x               <= '0;
      s1_y               <= '0;
      s1_lx              <= '0;
      s1_ly              <= '0;
      s1_lz              <= '0;
      s1_ux              <= '0;
      s1_uy              <= '0;
      s1_uz              <= '0;
      output_valid       <= 1'b0;
      out_last           <= 1'b0;
      core_image_x       <= '0;
      core_image_y       <= '0;
      core_ray_direction <= '0;
    end else if (ce) begin
      s1_valid <= issue;
      s1_last  <= issue && scan_last;
      s1_x     <= scan_x;
      s1_y     <= scan_y;
      s1_lx    <= mul_q(dx, cam_left[X_LO +: COMP_W]);
      s1_ly    <= mul_q(dx, cam_left[Y_LO +: COMP_W]);
      s1_lz    <= mul_q(dx, cam_left[Z_LO +: COMP_W]);
      s1_ux    <= mul_q(dy, cam_up[X_LO +: COMP_W]);
      s1_uy    <= mul_q(dy, cam_up[Y_LO +: COMP_W]);
      s1_uz    <= mul_q(dy, cam_up[Z_LO +: COMP_W]);

      output_valid       <= s1_valid;
      out_last           <= s1_last;
      core_image_x       <= s1_x;
      core_image_y       <= s1_y;
      core_ray_direction <= {cam_front[Z_LO +: COMP_W] + s1_lz + s1_uz,
                             cam_front[Y_LO +: COMP_W] + s1_ly + s1_uy,
                             cam_front[X_LO +: COMP_W] + s1_lx + s1_ux};
    end
  end

endmodule

// File: tb/tb_tiled_ray_caster.sv
// Directed bench for tiled_ray_caster: a 4x2 image with 2x2 tiles for order,
// stall, restart and reset behaviour, plus a default-size instance for wide arithmetic.
module tb_tiled_ray_caster;
  import ray_types_pkg::*;

  localparam logic [95:0] L0 = {32'h0, 32'h0, 32'h0100_0000};
  localparam logic [95:0] L1 = {32'h0, 32'h0, 32'h0300_0000};

  logic        clk = 1'b0;
  logic        rst, ce, ce2, render_start, start2, tile_mode;
  logic [95:0] origin, front, left, up;

  logic [3:0]  img_x, img_y;
  logic [95:0] ray_org, ray_dir;
  logic        valid, busy, done;

  logic [10:0] img_x2, img_y2;
  logic [95:0] ray_org2, ray_dir2;
  logic        valid2, busy2, done2;

  int errors = 0;
  int checks = 0;

  logic [3:0]  rec_x[$];
  logic [3:0]  rec_y[$];
  logic [95:0] rec_dir[$];
  logic [95:0] rec_org[$];
  int          fd_at[$];

  tiled_ray_caster #(
    .IMG_W(4), .IMG_H(2), .TILE_W(2), .TILE_H(2), .COORD_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .render_start(render_start), .tile_mode(tile_mode),
    .camera_origin(origin), .camera_front(front), .camera_left(left), .camera_up(up),
    .core_image_x(img_x), .core_image_y(img_y), .core_ray_origin(ray_org),
    .core_ray_direction(ray_dir), .output_valid(valid), .busy(busy), .frame_done(done)
  );

  tiled_ray_caster u_dut_full (
    .clk(clk), .rst(rst), .ce(ce2), .render_start(start2), .tile_mode(1'b0),
    .camera_origin(origin), .camera_front(front), .camera_left(left), .camera_up(up),
    .core_image_x(img_x2), .core_image_y(img_y2), .core_ray_origin(ray_org2),
    .core_ray_direction(ray_dir2), .output_valid(valid2), .busy(busy2), .frame_done(done2)
  );

  always #5 clk = ~clk;

  // Record every transfer and the transfer count at which frame_done is seen
  always @(negedge clk) begin
    if (!rst && valid && ce) begin
      rec_x.push_back(img_x);
      rec_y.push_back(img_y);
      rec_dir.push_back(ray_dir);
      rec_org.push_back(ray_org);
    end
    if (!rst && done) fd_at.push_back(rec_x.size());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] expDir(input int x, input int y, input int w, input int h,
                                         input logic [95:0] f, input logic [95:0] l,
                                         input logic [95:0] u);
    logic [95:0] r;
    int dx, dy, acc;
    dx = x - w / 2;
    dy = y - h / 2;
    r  = '0;
    for (int c = 0; c < 3; c++) begin
      acc = int'(f[c*32 +: 32]) + dx * int'(l[c*32 +: 32]) + dy * int'(u[c*32 +: 32]);
      r[c*32 +: 32] = acc;
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic tm, input logic [95:0] l);
    tile_mode    = tm;
    left         = l;
    render_start = 1'b1;
    tick();
    render_start = 1'b0;
  endtask

  task automatic clearRec;
    rec_x.delete();
    rec_y.delete();
    rec_dir.delete();
    rec_org.delete();
    fd_at.delete();
  endtask

  task automatic waitRays(input int n);
    int k = 0;
    while (rec_x.size() < n && k < 60) begin
      tick();
      k++;
    end
    checkOutput($sformatf("reach_%0d_rays", n), 96'(rec_x.size() >= n), 96'(1));
  endtask

  task automatic waitIdle(input string name);
    int k = 0;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    checkOutput({name, "_busy_fall"}, 96'(busy), 96'(0));
  endtask

  task automatic verifyFrame(input string name, input bit tiled, input logic [95:0] l);
    int ex, ey;
    checkOutput({name, "_count"}, 96'(rec_x.size()), 96'(8));
    for (int i = 0; i < rec_x.size() && i < 8; i++) begin
      if (tiled) begin
        ex = (i / 4) * 2 + (i % 4) % 2;
        ey = (i % 4) / 2;
      end else begin
        ex = i % 4;
        ey = i / 4;
      end
      checkOutput($sformatf("%s_xy%0d", name, i), 96'({rec_x[i], rec_y[i]}), 96'(ex * 16 + ey));
      checkOutput($sformatf("%s_dir%0d", name, i), rec_dir[i], expDir(ex, ey, 4, 2, front, l, up));
    end
    if (rec_org.size() > 0) checkOutput({name, "_origin"}, rec_org[0], origin);
    checkOutput({name, "_done_pulses"}, 96'(fd_at.size()), 96'(1));
    if (fd_at.size() > 0) checkOutput({name, "_done_with_last"}, 96'(fd_at[0]), 96'(8));
  endtask

  initial begin
    rst          = 1'b1;
    ce           = 1'b1;
    ce2          = 1'b1;
    render_start = 1'b0;
    start2       = 1'b0;
    tile_mode    = 1'b0;
    origin       = {32'hFB00_0000, 32'h0, 32'h0050_0000};
    front        = {ONE, 32'h0, 32'h0};
    left         = L0;
    up           = {32'h0, ONE, 32'h0};

    repeat (2) tick();
    checkOutput("reset_valid", 96'(valid), 96'(0));
    checkOutput("reset_busy", 96'(busy), 96'(0));
    checkOutput("reset_done", 96'(done), 96'(0));
    checkOutput("reset_xy", 96'({img_x, img_y}), 96'(0));
    checkOutput("reset_dir", ray_dir, 96'(0));
    checkOutput("reset_origin", ray_org, 96'(0));
    rst = 1'b0;
    tick();

    $display("[TB] raster frame");
    clearRec();
    applyStimulus(1'b0, L0);
    checkOutput("start_busy", 96'(busy), 96'(1));
    tick();
    checkOutput("latency_not_yet", 96'(valid), 96'(0));
    tick();
    checkOutput("latency_first", 96'(valid), 96'(1));
    checkOutput("first_xy", 96'({img_x, img_y}), 96'(0));
    checkOutput("first_dir", ray_dir, {32'h0100_0000, 32'hFF00_0000, 32'hFE00_0000});
    waitIdle("raster");
    checkOutput("raster_done_low", 96'(done), 96'(0));
    repeat (3) tick();
    verifyFrame("raster", 1'b0, L0);

    $display("[TB] tiled frame");
    clearRec();
    applyStimulus(1'b1, L0);
    waitIdle("tiled");
    repeat (3) tick();
    verifyFrame("tiled", 1'b1, L0);
    if (rec_dir.size() >= 8) checkOutput("tiled_last_dir", rec_dir[7], {ONE, 32'h0, 32'h0100_0000});

    $display("[TB] stall mid-frame");
    clearRec();
    applyStimulus(1'b0, L0);
    waitRays(3);
    ce = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("stall_valid%0d", s), 96'(valid), 96'(1));
      checkOutput($sformatf("stall_xy%0d", s), 96'({img_x, img_y}), 96'(3 * 16));
      checkOutput($sformatf("stall_dir%0d", s), ray_dir, expDir(3, 0, 4, 2, front, L0, up));
      checkOutput($sformatf("stall_done%0d", s), 96'({busy, done}), 96'(2));
      tick();
    end
    ce = 1'b1;
    waitIdle("stall");
    repeat (3) tick();
    verifyFrame("stall", 1'b0, L0);

    $display("[TB] restart while busy");
    clearRec();
    applyStimulus(1'b0, L0);
    waitRays(3);
    left         = L1;
    render_start = 1'b1;
    tick();
    render_start = 1'b0;
    waitIdle("restart");
    repeat (5) tick();
    verifyFrame("restart", 1'b0, L0);
    left = L0;

    $display("[TB] default-size instance");
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 10 && !valid2; k++) tick();
    checkOutput("full_first_valid", 96'(valid2), 96'(1));
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("full_xy%0d", k), 96'({img_x2, img_y2}), 96'(k * 2048));
      checkOutput($sformatf("full_dir%0d", k), ray_dir2, expDir(k, 0, 640, 480, front, L0, up));
      checkOutput($sformatf("full_origin_z%0d", k), 96'(ray_org2[95:64]), 96'(32'hFB00_0000));
      tick();
    end
    checkOutput("full_first_dir_hand", expDir(0, 0, 640, 480, front, L0, up),
                {ONE, 32'h1000_0000, 32'hC000_0000});
    checkOutput("full_busy_done", 96'({busy2, done2}), 96'(2));

    $display("[TB] reset mid-frame");
    clearRec();
    applyStimulus(1'b0, L0);
    waitRays(4);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 96'(valid), 96'(0));
    checkOutput("midrst_busy_done", 96'({busy, done}), 96'(0));
    checkOutput("midrst_xy", 96'({img_x, img_y}), 96'(0));
    checkOutput("midrst_dir", ray_dir, 96'(0));
    checkOutput("midrst_origin", ray_org, 96'(0));
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("midrst_no_done", 96'(fd_at.size()), 96'(0));
    checkOutput("midrst_idle", 96'({valid, busy}), 96'(0));
    clearRec();
    applyStimulus(1'b0, L0);
    waitIdle("after_reset");
    repeat (3) tick();
    verifyFrame("after_reset", 1'b0, L0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
